// File: rtl/rvc_asap_5pl_vga_fb.sv
// Double-buffered VGA frame buffer: core port A, VGA port B, deferred flip.
// Optional back-page clear engine under RVC_ASAP_VGA_FB_CLEAR_EN.
module rvc_asap_5pl_vga_fb #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 9600,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [AW:0]       address_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W/8-1:0] byteena_a,
  input  logic              wren_a,
  input  logic              rden_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [AW-1:0]     address_b,
  output logic [DATA_W-1:0] q_b,
  input  logic              frame_start,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              front_page,
  input  logic              clear_req,
  output logic              clear_busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [DATA_W-1:0] mem [2][DEPTH];

  logic          front_q;
  logic [0:0]    swap_st;
  logic          clearing;
  logic          sel_front;
  logic          pg_a;
  logic [AW-1:0] idx_a;
  logic          in_a;
  logic          in_b;
  logic          back_blk;
  logic          wr_ok;
  logic          rd_ok;
  logic          flip;

  assign sel_front = address_a[AW];
  assign pg_a      = sel_front ? front_q : ~front_q;
  assign idx_a     = address_a[AW-1:0];
  assign in_a      = idx_a <= LAST;
  assign in_b      = address_b <= LAST;
  assign back_blk  = clearing & ~sel_front;
  assign wr_ok     = wren_a & in_a & ~back_blk;
  assign rd_ok     = rden_a & in_a & ~back_blk;
  assign flip      = (swap_st == S_PEND) & frame_start & ~clearing;

`ifdef RVC_ASAP_VGA_FB_CLEAR_EN
  localparam logic [0:0] C_IDLE  = 1'b0;
  localparam logic [0:0] C_CLEAR = 1'b1;

  logic [0:0]    clr_st;
  logic [AW-1:0] clr_cnt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      clr_st  <= C_IDLE;
      clr_cnt <= '0;
    end else begin
      unique case (clr_st)
        C_IDLE: begin
          if (clear_req) begin
            clr_st  <= C_CLEAR;
            clr_cnt <= '0;
          end
        end
        C_CLEAR: begin
          if (clr_cnt == LAST) begin
            clr_st  <= C_IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: clr_st <= C_IDLE;
      endcase
    end
  end

  assign clearing = (clr_st == C_CLEAR);
`else
  logic unused;
  assign unused   = clear_req;
  assign clearing = 1'b0;
`endif

  assign clear_busy = clearing;

  // Page contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (byteena_a[b]) begin
          mem[pg_a][idx_a][b*8 +: 8] <= data_a[b*8 +: 8];
        end
      end
    end
`ifdef RVC_ASAP_VGA_FB_CLEAR_EN
    if (clearing) begin
      mem[~front_q][clr_cnt] <= '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      swap_st <= S_IDLE;
      front_q <= 1'b0;
    end else begin
      unique case (swap_st)
        S_IDLE: begin
          if (swap_req) swap_st <= S_PEND;
        end
        S_PEND: begin
          if (flip) begin
            swap_st <= S_IDLE;
            front_q <= ~front_q;
          end
        end
        default: swap_st <= S_IDLE;
      endcase
    end
  end

  assign swap_pending = (swap_st == S_PEND);
  assign front_page   = front_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= rd_ok ? mem[pg_a][idx_a] : '0;
      q_b <= in_b ? mem[front_q][address_b] : '0;
    end
  end

endmodule
